// File: rtl/serial_frame_deser_pkg.sv
// Types and default parameters shared by the serial deserialiser and the shift-register bench.
package serial_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } deser_state_t;

    localparam int         DEF_WIDTH       = 8;
    localparam logic [7:0] DEF_SYNC_WORD   = 8'hA5;
    localparam int         DEF_FRAME_WORDS = 4;

endpackage

// File: rtl/serial_frame_deser_if.sv
// Serial input / word output bundle of serial_frame_deser.
// master = deserialiser side, slave = bit source plus word consumer.
interface serial_frame_deser_if #(
    parameter int WIDTH = 8
);
    logic             bit_valid;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             frame_start;
    logic             in_sync;
    logic             overrun;
    logic             parity_err;

    modport master (
        input  bit_valid, serial_in, data_ready,
        output data_out, data_valid, frame_start, in_sync, overrun, parity_err
    );

    modport slave (
        output bit_valid, serial_in, data_ready,
        input  data_out, data_valid, frame_start, in_sync, overrun, parity_err
    );
endinterface

// File: rtl/serial_frame_deser_sync.sv
// Sync-word hunter: WIDTH-bit sliding window plus a saturating fill count.
// match compares the post-shift window, so it is valid in the same cycle as the accepted bit.
module sync_word_detect
    import serial_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEF_SYNC_WORD)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_valid,
    input  logic serial_in,
    output logic match
);
    localparam int HC_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_window;
    logic [WIDTH-1:0] w_window_next;
    logic [HC_W-1:0]  r_hunt_cnt;
    logic [HC_W-1:0]  w_hunt_cnt_next;

    always_comb begin
        w_window_next   = {r_window[WIDTH-2:0], serial_in};
        w_hunt_cnt_next = (r_hunt_cnt == HC_W'(WIDTH)) ? r_hunt_cnt : r_hunt_cnt + 1'b1;
    end

    // A full window is required, so a freshly cleared window never matches even an all-zero sync word.
    assign match = bit_valid && (w_hunt_cnt_next == HC_W'(WIDTH)) && (w_window_next == SYNC_WORD);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_window   <= '0;
            r_hunt_cnt <= '0;
        end else if (bit_valid) begin
            r_window   <= w_window_next;
            r_hunt_cnt <= w_hunt_cnt_next;
        end
    end
endmodule

// File: rtl/serial_frame_deser.sv
// Serial frame deserialiser: hunts a sync word, then emits FRAME_WORDS MSB-first words on a valid/ready register.
// Define PARITY_CHECK_EN to expect an even-parity bit after every data word.
module serial_frame_deser
    import serial_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(DEF_SYNC_WORD),
    parameter int               FRAME_WORDS = DEF_FRAME_WORDS
) (
    input logic                  clk,
    input logic                  reset,
    serial_frame_deser_if.master bus
);
    localparam int BC_W = $clog2(WIDTH);
    localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
`ifdef PARITY_CHECK_EN
    localparam int SH_W = WIDTH;
`else
    localparam int SH_W = WIDTH - 1;
`endif

    deser_state_t     r_state, w_state_next;
    logic [SH_W-1:0]  r_shift;
    logic [WIDTH-1:0] w_shift_shifted;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [WC_W-1:0]  r_word_cnt;
    logic             w_hunt_bit, w_match, w_bit_last;
    logic             w_word_done, w_frame_done, w_load_ok, w_perr;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid, r_frame_start, r_overrun, r_parity_err;

    assign w_hunt_bit      = bus.bit_valid && (r_state == HUNT);
    assign w_shift_shifted = {r_shift[WIDTH-2:0], bus.serial_in};
    assign w_bit_last      = (r_bit_cnt == BC_W'(WIDTH - 1));
    assign w_load_ok       = !r_data_valid || bus.data_ready;

    sync_word_detect #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_frame_done),
        .bit_valid (w_hunt_bit),
        .serial_in (bus.serial_in),
        .match     (w_match)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= HUNT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_word_done  = 1'b0;
        w_perr       = 1'b0;
`ifdef PARITY_CHECK_EN
        w_word       = r_shift;
`else
        w_word       = w_shift_shifted;
`endif
        case (r_state)
            HUNT: begin
                if (w_match) w_state_next = COLLECT;
            end
            COLLECT: begin
                if (bus.bit_valid && w_bit_last) begin
`ifdef PARITY_CHECK_EN
                    w_state_next = PARITY;
`else
                    w_word_done  = 1'b1;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (bus.bit_valid) begin
                    w_word_done = 1'b1;
                    w_perr      = ^{r_shift, bus.serial_in};
                end
            end
`endif
            default: w_state_next = HUNT;
        endcase
        w_frame_done = w_word_done && (r_word_cnt == WC_W'(FRAME_WORDS - 1));
        if (w_word_done) w_state_next = w_frame_done ? HUNT : COLLECT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_overrun     <= 1'b0;
            r_parity_err  <= 1'b0;
        end else begin
            if (r_state == COLLECT && bus.bit_valid) begin
                r_shift   <= w_shift_shifted[SH_W-1:0];
                r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
            end
            if (w_match) begin
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
            end
            if (w_word_done) r_word_cnt <= w_frame_done ? '0 : r_word_cnt + 1'b1;

            // A load may coincide with the consumer taking the previous word, so back-to-back words have no bubble.
            if (w_word_done && w_load_ok) begin
                r_data_out    <= w_word;
                r_data_valid  <= 1'b1;
                r_frame_start <= (r_word_cnt == '0);
                r_parity_err  <= w_perr;
            end else begin
                if (w_word_done) r_overrun <= 1'b1;
                if (r_data_valid && bus.data_ready) begin
                    r_data_valid  <= 1'b0;
                    r_frame_start <= 1'b0;
                    r_parity_err  <= 1'b0;
                end
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.data_valid  = r_data_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.in_sync     = (r_state != HUNT);
    assign bus.overrun     = r_overrun;
    assign bus.parity_err  = r_parity_err;
endmodule

// File: tb/tb_serial_frame_deser.sv
// Scoreboard bench for serial_frame_deser; the stimulus pushes expected words, a monitor pops them on presentation.
// Define PARITY_CHECK_EN to build the parity variant and its extra frame.
module tb_serial_frame_deser;
    import serial_pkg::*;

    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         fs;
        logic         perr;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_deser_if #(.WIDTH(W)) bus ();

    serial_frame_deser #(
        .WIDTH       (W),
        .SYNC_WORD   (8'hA5),
        .FRAME_WORDS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a new word is on the bus when valid rises or stays high right after a handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (bus.data_valid && (!prev_valid || prev_hs)) begin
                $display("rx word=%02h frame_start=%b parity_err=%b cyc=%0d",
                         bus.data_out, bus.frame_start, bus.parity_err, cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %02h expected no word", bus.data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data_out",    32'(bus.data_out),    32'(mon_e.data));
                    check("frame_start", 32'(bus.frame_start), 32'(mon_e.fs));
                    check("parity_err",  32'(bus.parity_err),  32'(mon_e.perr));
                    check("latency_cyc", cyc,                  mon_e.cyc);
                end
            end
            prev_valid = bus.data_valid;
            prev_hs    = bus.data_valid && bus.data_ready;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.bit_valid = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic b, input int gap, output int at);
        idle(gap);
        @(posedge clk); #1;
        bus.bit_valid = 1'b1;
        bus.serial_in = b;
        at = cyc;
    endtask

    // Sends one word MSB first; data words get an even-parity bit (inverted when flip) in the parity build.
    task automatic send_word(input logic [W-1:0] v, input bit data, input bit push,
                             input bit fs, input bit flip, input bit gaps);
        int at;
        int g;
        at = 0;
        for (int i = W - 1; i >= 0; i--) begin
            g = (gaps && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
            drive_bit(v[i], g, at);
        end
        if (PAR_EN && data) begin
            g = gaps ? int'($urandom_range(0, 3)) : 0;
            drive_bit((^v) ^ flip, g, at);
        end
        if (push) exp_q.push_back('{v, fs, PAR_EN && data && flip, at + 1});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"},    32'(bus.data_out),    32'h0);
        check({tag, "_data_valid"},  32'(bus.data_valid),  32'h0);
        check({tag, "_frame_start"}, 32'(bus.frame_start), 32'h0);
        check({tag, "_in_sync"},     32'(bus.in_sync),     32'h0);
        check({tag, "_overrun"},     32'(bus.overrun),     32'h0);
        check({tag, "_parity_err"},  32'(bus.parity_err),  32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.bit_valid  = 1'b0;
        bus.serial_in  = 1'b0;
        bus.data_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // 1: continuous frame, consumer always ready
        send_word(8'hA5, 0, 0, 0, 0, 0);
        fork begin @(posedge clk); @(negedge clk); check("in_sync_at_match", 32'(bus.in_sync), 32'h1); end join_none
        send_word(8'h11, 1, 1, 1, 0, 0);
        send_word(8'h22, 1, 1, 0, 0, 0);
        send_word(8'h33, 1, 1, 0, 0, 0);
        send_word(8'h44, 1, 1, 0, 0, 0);
        fork begin @(posedge clk); @(negedge clk); check("in_sync_after_last", 32'(bus.in_sync), 32'h0); end join_none
        idle(4);

        // 2: noise that must not sync, then a frame
        send_word(8'hFF, 0, 0, 0, 0, 0);
        send_word(8'h5A, 0, 0, 0, 0, 0);
        fork begin @(posedge clk); @(negedge clk); check("in_sync_noise", 32'(bus.in_sync), 32'h0); end join_none
        send_word(8'hA5, 0, 0, 0, 0, 0);
        send_word(8'h01, 1, 1, 1, 0, 0);
        send_word(8'h02, 1, 1, 0, 0, 0);
        send_word(8'h03, 1, 1, 0, 0, 0);
        send_word(8'h04, 1, 1, 0, 0, 0);
        idle(4);
        @(negedge clk);
        check("overrun_clean", 32'(bus.overrun), 32'h0);

        // 3: consumer stalls through word 1
        @(posedge clk); #1;
        bus.data_ready = 1'b0;
        send_word(8'hA5, 0, 0, 0, 0, 0);
        send_word(8'h11, 1, 1, 1, 0, 0);
        send_word(8'h22, 1, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        check("stall_data_out",   32'(bus.data_out),   32'h11);
        check("stall_data_valid", 32'(bus.data_valid), 32'h1);
        check("stall_overrun",    32'(bus.overrun),    32'h1);
        @(posedge clk); #1;
        bus.data_ready = 1'b1;
        send_word(8'h33, 1, 1, 0, 0, 0);
        send_word(8'h44, 1, 1, 0, 0, 0);
        idle(4);
        @(negedge clk);
        check("overrun_sticky", 32'(bus.overrun), 32'h1);

        // 4: same frame with bit_valid gaps
        send_word(8'hA5, 0, 0, 0, 0, 1);
        send_word(8'h11, 1, 1, 1, 0, 1);
        send_word(8'h22, 1, 1, 0, 0, 1);
        send_word(8'h33, 1, 1, 0, 0, 1);
        send_word(8'h44, 1, 1, 0, 0, 1);
        idle(4);
        @(negedge clk);
        check("overrun_still_set", 32'(bus.overrun), 32'h1);

        // 5: reset three bits into word 22, then a clean frame
        begin
            int at;
            send_word(8'hA5, 0, 0, 0, 0, 0);
            send_word(8'h11, 1, 1, 1, 0, 0);
            drive_bit(1'b0, 0, at);
            drive_bit(1'b0, 0, at);
            drive_bit(1'b1, 0, at);
        end
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        send_word(8'hA5, 0, 0, 0, 0, 0);
        send_word(8'h55, 1, 1, 1, 0, 0);
        send_word(8'h66, 1, 1, 0, 0, 0);
        send_word(8'h77, 1, 1, 0, 0, 0);
        send_word(8'h88, 1, 1, 0, 0, 0);
        idle(4);

        // 6: parity frame, word 22 carries a wrong parity bit
        if (PAR_EN) begin
            send_word(8'hA5, 0, 0, 0, 0, 0);
            send_word(8'h11, 1, 1, 1, 0, 0);
            send_word(8'h22, 1, 1, 0, 1, 0);
            send_word(8'h33, 1, 1, 0, 0, 0);
            send_word(8'h44, 1, 1, 0, 0, 0);
            idle(4);
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
